ctrl_unit: RTL

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/ctrl_unit.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_unit.sv
// ---------------------------------------------------------------------------
// ctrl_unit -- multi-cycle MIPS-subset control unit (Moore FSM)
//
// Sequences each instruction through FETCH / DECODE / execute / memory /
// write-back states and decodes every datapath strobe from the current
// state. The only non-state inputs used by the strobe decoder are the
// instruction fields (valid from DECODE onward) and the ALU zero flag
// (branch resolution).
//
// Parameters
//   MEM_WAIT      memory read latency in cycles (1..7); FETCH and MEM_RD
//                 each last MEM_WAIT+1 cycles
//
// Ports
//   clock         single clock, all state updates on the rising edge
//   reset_n       synchronous, active-low reset
//   opcode        IR[31:26]
//   funct         IR[5:0]
//   zero          ALU zero flag
//   overflow      ALU signed-overflow flag
//   alu_sum       force the ALU to add
//   alu_src_a     ALU A mux: 0=PC, 1=A
//   alu_src_b     ALU B mux: 0=B, 1=4, 2=sext imm, 3=sext imm<<2
//   pc_write      PC load strobe
//   pc_src        PC mux: 0=ALU result, 1=ALUOut, 2=jump target, 3=exc vector
//   iord          memory address mux: 0=PC, 1=ALUOut
//   mem_write     memory write strobe
//   ir_write      IR load strobe
//   aluout_write  ALUOut load strobe
//   reg_write     register file write strobe
//   reg_dst       destination register: 0=rt, 1=rd
//   mem_to_reg    write-back mux: 0=ALUOut, 1=MDR, 2=imm<<16
//   epc_write     EPC load strobe
//   exc_cause     0=none, 1=bad opcode/funct, 2=overflow (sticky)
//   halted        high while in HALT
//   instr_done    one-cycle pulse on the last cycle of a retired instruction
//   state         current state code (debug)
// ---------------------------------------------------------------------------
module ctrl_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       alu_sum,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       epc_write,
  output logic [1:0] exc_cause,
  output logic       halted,
  output logic       instr_done,
  output logic [3:0] state
);

  // -------------------------------------------------------------------------
  // State encoding (codes are visible on the debug port and must not move)
  // -------------------------------------------------------------------------
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_MEM_WR = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_EXCEPT = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;

  // Instruction encodings
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_HALT  = 6'h0d;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BAD  = 2'd1;
  localparam logic [1:0] CAUSE_OVF  = 2'd2;

  // Wait counter runs 0..MEM_WAIT inside FETCH and MEM_RD.
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic [2:0] wait_cnt;
  logic [2:0] nxt_wait;
  logic [1:0] cause_q;
  logic [1:0] nxt_cause;

  logic       wait_first;
  logic       wait_last;

  assign wait_first = (wait_cnt == 3'd0);
  assign wait_last  = (wait_cnt == WAIT_LAST);

  // -------------------------------------------------------------------------
  // Instruction classification
  // -------------------------------------------------------------------------
  logic is_rtype_alu;
  logic is_halt;
  logic is_itype;
  logic is_mem;
  logic is_branch;
  logic is_jump;
  logic ovf_trap;

  always_comb begin
    is_rtype_alu = (opcode == OP_RTYPE) &&
                   ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND));
    is_halt      = (opcode == OP_RTYPE) && (funct == FN_HALT);
    is_itype     = (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_LUI);
    is_mem       = (opcode == OP_LW) || (opcode == OP_SW);
    is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jump      = (opcode == OP_J);
    // Only the trapping arithmetic ops care about overflow: add, sub, addi.
    // addiu, and, and lui retire normally regardless of the flag.
    ovf_trap     = overflow &&
                   (((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
                    (opcode == OP_ADDI));
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    nxt_state = cur_state;
    nxt_wait  = 3'd0;        // every entry into a waiting state starts at 0
    nxt_cause = cause_q;
    case (cur_state)
      S_RST:    nxt_state = S_FETCH;
      S_FETCH: begin
        if (wait_last) nxt_state = S_DECODE;
        else           nxt_wait  = wait_cnt + 3'd1;
      end
      S_DECODE: begin
        if (is_rtype_alu)   nxt_state = S_EXEC_R;
        else if (is_halt)   nxt_state = S_HALT;
        else if (is_itype)  nxt_state = S_EXEC_I;
        else if (is_mem)    nxt_state = S_ADDR;
        else if (is_branch) nxt_state = S_BRANCH;
        else if (is_jump)   nxt_state = S_JUMP;
        else begin
          nxt_state = S_EXCEPT;
          nxt_cause = CAUSE_BAD;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        if (ovf_trap) begin
          nxt_state = S_EXCEPT;
          nxt_cause = CAUSE_OVF;
        end else begin
          nxt_state = S_WB_ALU;
        end
      end
      S_ADDR:   nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (wait_last) nxt_state = S_WB_MEM;
        else           nxt_wait  = wait_cnt + 3'd1;
      end
      S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_EXCEPT:
                nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;   // only reset leaves HALT
      default:  nxt_state = S_RST;    // unused codes recover via RST
    endcase
  end

  // Reset wins over every transition, including mid-wait and pending traps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state <= S_RST;
      wait_cnt  <= 3'd0;
      cause_q   <= CAUSE_NONE;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= nxt_wait;
      cause_q   <= nxt_cause;
    end
  end

  // -------------------------------------------------------------------------
  // Strobe decode (Moore: state, wait position, IR fields, zero)
  // -------------------------------------------------------------------------
  always_comb begin
    alu_sum      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 2'd0;
    epc_write    = 1'b0;
    halted       = 1'b0;
    instr_done   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        // PC+4 is committed on the first cycle; the instruction word is
        // only captured once the memory latency has elapsed.
        if (wait_first) begin
          alu_sum   = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        if (wait_last) ir_write = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm<<2) into ALUOut.
        alu_sum      = 1'b1;
        alu_src_b    = 2'd3;
        aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a    = 1'b1;
        aluout_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        aluout_write = 1'b1;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LUI) ? 2'd2 : 2'd0;
      end
      S_MEM_RD: iord = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // ALU compares A-B; the target was parked in ALUOut during DECODE.
        alu_src_a  = 1'b1;
        pc_src     = 2'd1;
        pc_write   = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXCEPT: begin
        // The faulting instruction does not retire, so no instr_done.
        epc_write = 1'b1;
        pc_src    = 2'd3;
        pc_write  = 1'b1;
      end
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

  assign exc_cause = cause_q;
  assign state     = cur_state;

endmodule
